// File: rtl/audio_fifo_pkg.sv
// Shared sizes and types for the audio sample FIFO player.
package audio_fifo_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int USED_W = ADDR_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [USED_W-1:0] used_t;

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port sample RAM, one write port and one enabled registered read port.
// Latency: read data valid one clock after rd_en; read-during-write to one address returns old data.
// Backpressure: none, the caller guarantees legal addresses.
module fifo_ram_sdp
  import audio_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  sample_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/audio_fifo_player.sv
// Buffers PIO-written audio samples in a 2048-word FIFO and replays them at a divider-set rate.
// Latency: a sample appears on sample_data with sample_valid one clock after its rate tick.
// Backpressure: none; writes to a full FIFO are dropped (overflow), ticks on empty set underrun.
module audio_fifo_player
  import audio_fifo_pkg::*;
(
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_req,
  input  logic              wr_strobe,
  input  logic              pause,
  input  logic              stop,
  input  logic [31:0]       div_freq,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [USED_W-1:0] fifo_used,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              overflow,
  output logic              underrun
);

  logic    strobe_q;
  logic    stop_q;
  addr_t   wptr;
  addr_t   rptr;
  logic [31:0] cnt;
  logic    rd_pend_q;
  sample_t held_q;
  sample_t ram_q;
  used_t   used_nxt;

  logic wr_ev;
  logic run;
  logic tick;
  logic pop;
  logic push;
  logic stop_rise;

  assign wr_ev     = wr_strobe & ~strobe_q & wr_req;
  assign run       = ~stop & ~pause & (div_freq != 32'd0);
  // >= rather than == so a shrinking divider ticks at once instead of wrapping cnt
  assign tick      = run & (cnt >= div_freq - 32'd1);
  assign pop       = tick & ~fifo_empty;
  assign push      = wr_ev & ~stop & (~fifo_full | pop);
  assign stop_rise = stop & ~stop_q;

  // A read landing while stop is high is discarded rather than presented
  assign sample_valid = rd_pend_q & ~stop;
  assign sample_data  = sample_valid ? ram_q : held_q;

  always_comb begin
    used_nxt = fifo_used;
    case ({push, pop})
      2'b10:   used_nxt = fifo_used + used_t'(1);
      2'b01:   used_nxt = fifo_used - used_t'(1);
      default: used_nxt = fifo_used;
    endcase
    if (stop) used_nxt = '0;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      strobe_q   <= 1'b0;
      stop_q     <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      rd_pend_q  <= 1'b0;
      held_q     <= '0;
      fifo_used  <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      strobe_q   <= wr_strobe;
      stop_q     <= stop;
      rd_pend_q  <= pop;
      fifo_used  <= used_nxt;
      fifo_full  <= (used_nxt == used_t'(DEPTH));
      fifo_empty <= (used_nxt == '0);

      if (stop) begin
        wptr   <= '0;
        rptr   <= '0;
        cnt    <= '0;
        held_q <= '0;
      end else begin
        if (push) wptr <= wptr + addr_t'(1);
        if (pop)  rptr <= rptr + addr_t'(1);
        if (tick)
          cnt <= '0;
        else if (run)
          cnt <= cnt + 32'd1;
        else if (div_freq == 32'd0)
          cnt <= '0;
        if (sample_valid) held_q <= ram_q;
      end

      if (stop_rise)
        overflow <= 1'b0;
      else if (wr_ev & ~stop & fifo_full & ~pop)
        overflow <= 1'b1;

      if (stop_rise)
        underrun <= 1'b0;
      else if (tick & fifo_empty)
        underrun <= 1'b1;
    end
  end

  fifo_ram_sdp u_ram (
    .clk     (clk_clk),
    .wr_en   (push),
    .wr_addr (wptr),
    .wr_dat  (wr_data),
    .rd_en   (pop),
    .rd_addr (rptr),
    .rd_dat  (ram_q)
  );

endmodule

// File: tb/tb_audio_fifo_player.sv
// Directed bench for audio_fifo_player: write, playback, pause, full/overflow, stop.
module tb_audio_fifo_player;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [31:0] wr_data;
  logic        wr_req;
  logic        wr_strobe;
  logic        pause;
  logic        stop;
  logic [31:0] div_freq;
  logic        fifo_full;
  logic        fifo_empty;
  logic [11:0] fifo_used;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        overflow;
  logic        underrun;

  int n_chk    = 0;
  int n_fail   = 0;
  int vld_seen = 0;

  always #5 clk_clk = ~clk_clk;

  audio_fifo_player dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .wr_data       (wr_data),
    .wr_req        (wr_req),
    .wr_strobe     (wr_strobe),
    .pause         (pause),
    .stop          (stop),
    .div_freq      (div_freq),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_used     (fifo_used),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .overflow      (overflow),
    .underrun      (underrun)
  );

  always @(negedge clk_clk) begin
    if (sample_valid === 1'b1) vld_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] d);
    wr_data   = d;
    wr_req    = 1'b1;
    wr_strobe = 1'b1;
    cyc();
    wr_strobe = 1'b0;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_reset_n = 1'b0;
    wr_data   = '0;
    wr_req    = 1'b0;
    wr_strobe = 1'b0;
    pause     = 1'b0;
    stop      = 1'b0;
    div_freq  = '0;
    cyc();
    cyc();
    chk("rst_used",  fifo_used,    0);
    chk("rst_empty", fifo_empty,   1);
    chk("rst_full",  fifo_full,    0);
    chk("rst_data",  sample_data,  0);
    chk("rst_vld",   sample_valid, 0);
    chk("rst_ovf",   overflow,     0);
    chk("rst_udr",   underrun,     0);
    reset_reset_n = 1'b1;
    cyc();

    // three words with the divider off
    write_word(32'h11);
    write_word(32'h22);
    write_word(32'h33);
    chk("wr3_used",  fifo_used,  3);
    chk("wr3_empty", fifo_empty, 0);
    chk("wr3_novld", vld_seen,   0);

    // playback at one sample per 4 clocks, then an underrun tick
    div_freq = 32'd4;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if ((i % 4 == 0) && (i <= 12)) begin
        chk("play_vld", sample_valid, 1);
        chk("play_dat", sample_data, 32'h11 * (i / 4));
      end else begin
        chk("play_idle", sample_valid, 0);
      end
    end
    chk("udr_set",   underrun,    1);
    chk("udr_hold",  sample_data, 32'h33);
    chk("udr_empty", fifo_empty,  1);
    div_freq = 32'd0;

    // a held strobe writes once; an edge without wr_req writes nothing
    wr_data   = 32'h44;
    wr_req    = 1'b1;
    wr_strobe = 1'b1;
    repeat (10) cyc();
    wr_strobe = 1'b0;
    cyc();
    chk("held_used", fifo_used, 1);
    wr_req    = 1'b0;
    wr_data   = 32'hEE;
    wr_strobe = 1'b1;
    cyc();
    wr_strobe = 1'b0;
    cyc();
    chk("noreq_used", fifo_used, 1);
    write_word(32'h55);
    write_word(32'h66);
    write_word(32'h77);
    write_word(32'h88);
    chk("pre_pause_used", fifo_used, 5);

    // pause mid-playback: counter freezes at 2, one write lands during pause
    div_freq = 32'd4;
    repeat (4) cyc();
    chk("p_first_vld", sample_valid, 1);
    chk("p_first_dat", sample_data, 32'h44);
    cyc();
    cyc();
    pause   = 1'b1;
    wr_data = 32'h99;
    wr_req  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_strobe = (i == 5);
      cyc();
      chk("pause_vld", sample_valid, 0);
    end
    wr_strobe = 1'b0;
    chk("pause_hold", sample_data, 32'h44);
    chk("pause_used", fifo_used, 5);
    pause = 1'b0;
    cyc();
    chk("resume_r1", sample_valid, 0);
    cyc();
    chk("resume_vld", sample_valid, 1);
    chk("resume_dat", sample_data, 32'h55);
    div_freq = 32'd0;
    chk("resume_used", fifo_used, 4);

    // fill to full, then drop one write
    for (int i = 0; i < 2044; i++) write_word(32'h1000 + i);
    chk("full_flag", fifo_full, 1);
    chk("full_used", fifo_used, 2048);
    chk("full_ovf0", overflow,  0);
    write_word(32'hDEAD);
    chk("ovf_set",   overflow,  1);
    chk("ovf_used",  fifo_used, 2048);
    chk("ovf_full",  fifo_full, 1);

    // push and pop together while full
    wr_data   = 32'hABC;
    wr_req    = 1'b1;
    wr_strobe = 1'b1;
    div_freq  = 32'd1;
    cyc();
    chk("pp_used", fifo_used,    2048);
    chk("pp_full", fifo_full,    1);
    chk("pp_vld",  sample_valid, 1);
    chk("pp_dat",  sample_data,  32'h66);
    wr_strobe = 1'b0;

    // drain to 100 words at one pop per clock
    repeat (1948) cyc();
    chk("drain_used", fifo_used,    100);
    chk("drain_ovf",  overflow,     1);
    chk("drain_udr",  underrun,     1);
    chk("drain_vld",  sample_valid, 1);

    // stop with a simultaneous write and a read in flight
    div_freq  = 32'd0;
    stop      = 1'b1;
    wr_data   = 32'h5555;
    wr_req    = 1'b1;
    wr_strobe = 1'b1;
    #1;
    chk("stop_inflight", sample_valid, 0);
    cyc();
    chk("stop_used",  fifo_used,    0);
    chk("stop_empty", fifo_empty,   1);
    chk("stop_full",  fifo_full,    0);
    chk("stop_data",  sample_data,  0);
    chk("stop_ovf",   overflow,     0);
    chk("stop_udr",   underrun,     0);
    chk("stop_vld",   sample_valid, 0);
    stop      = 1'b0;
    wr_strobe = 1'b0;
    cyc();
    chk("post_stop_used",  fifo_used,  0);
    chk("post_stop_empty", fifo_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_fifo_player.md
Name: audio_fifo_player

Overview:
- Consumes the audio2fifo PIO conduit (sample word, write request, software write strobe, pause, stop, rate divider) and buffers samples in an on-chip FIFO.
- Returns full, empty and used status to the PIO inputs.
- Replays buffered samples at the divider-defined rate to the downstream codec/modulation stage.
- Sits between the Nios Qsys system and the audio output path.

Parameters:
- ADDR_W, 11, FIFO address width; depth = 2**ADDR_W = 2048 words.
- DATA_W, 32, sample word width.
- USED_W, 12, width of the used count (ADDR_W+1, range 0..2048).

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  synchronous active-low reset.
- wr_data  in  32  sample word from the PIO (out_data_audio).
- wr_req  in  1  write enable level from the PIO (wrreq).
- wr_strobe  in  1  software write strobe from the PIO (wrclk); a write is its rising edge.
- pause  in  1  hold playback.
- stop  in  1  flush the FIFO and silence the output.
- div_freq  in  32  clocks per output sample (data_divfrec).
- fifo_full  out  1  FIFO holds 2048 words.
- fifo_empty  out  1  FIFO holds 0 words.
- fifo_used  out  12  current occupancy.
- sample_data  out  32  current output sample.
- sample_valid  out  1  one-cycle pulse when sample_data updates.
- overflow  out  1  sticky; a write was dropped because the FIFO was full.
- underrun  out  1  sticky; a tick occurred while the FIFO was empty.

Behaviour:
- Clocking: one clock, clk_clk. Reset is synchronous, active-low on reset_reset_n. All PIO inputs are in the clk_clk domain; no synchronizers.
- Reset values:
  - pointers 0, fifo_used 0, fifo_empty 1, fifo_full 0.
  - sample_data 0, sample_valid 0, overflow 0, underrun 0.
  - divider counter 0, strobe edge register 0.
- Write path:
  - strobe_q <= wr_strobe each cycle.
  - Write event = wr_strobe & ~strobe_q & wr_req.
  - If not full: store wr_data at wptr and increment wptr (wraps modulo 2048).
  - If full: drop the word and set overflow.
- Rate divider:
  - cnt increments each cycle while pause=0 and div_freq!=0.
  - When cnt == div_freq-1: tick=1 and cnt <= 0.
  - div_freq==0: no ticks, cnt held at 0.
  - pause=1: cnt frozen, no ticks.
  - A change of div_freq takes effect immediately; if cnt >= new div_freq-1 the next cycle ticks.
- Read path:
  - On tick with FIFO not empty: pop at rptr and increment rptr (wraps).
  - The RAM read is registered, so sample_data is loaded and sample_valid pulses exactly 1 cycle after the tick cycle.
  - On tick with FIFO empty: set underrun; sample_data holds its last value; no sample_valid.
- Occupancy:
  - Push only: used+1. Pop only: used-1. Push and pop in the same cycle: used unchanged (allowed even when full, since the pop frees a slot that cycle).
  - fifo_full = (used==2048); fifo_empty = (used==0). Both are registered and consistent with fifo_used in the same cycle.
- Stop (priority over all other events):
  - While stop=1: pointers and used forced to 0, sample_data <= 0, cnt <= 0.
  - Any write that cycle is dropped without setting overflow.
  - An in-flight read completing in the cycle stop asserts is discarded (no sample_valid).
  - overflow and underrun are cleared on the rising edge of stop (stop acts as software clear).
- Pause: writes still accepted; status outputs keep updating; sample_data held.
- Reset mid-operation: all state returns to reset values on the next clock edge; FIFO RAM contents need not be cleared.

Decomposition:
- Shared package audio_fifo_pkg: ADDR_W, DATA_W, USED_W constants; depth constant; sample_t typedef (logic [31:0]).
- Sub-module fifo_ram_sdp: simple dual-port RAM, 2048x32, one write port, one registered read port. Infers M10K.
- Top holds pointers, occupancy, edge detect, divider, flags.

Test Plan:
- Reset, then write 3 words (0x11,0x22,0x33) via strobe edges with wr_req=1, div_freq=0 -> fifo_used=3, empty=0, no sample_valid.
- div_freq=4 with the 3 words buffered -> sample_valid pulses every 4 clocks carrying 0x11, 0x22, 0x33. The next tick sets underrun; sample_data stays 0x33.
- Fill with 2048 writes -> fifo_full=1, used=2048. A 2049th write is dropped, overflow=1, used stays 2048. Push and pop in the same cycle while full keeps used=2048.
- Strobe held high for 10 cycles with wr_req=1 -> exactly one write. Strobe edge with wr_req=0 -> no write.
- pause=1 for 20 cycles mid-playback at div_freq=4 -> no sample_valid and cnt frozen. Release -> the next tick arrives after the remaining count.
- stop pulse with used=100 and an overflow pending -> used=0, empty=1, sample_data=0, overflow cleared. A simultaneous write is ignored.
